// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int MIN_DIV = 2;

    // Codes 00 and 11 both mean no parity.
    function automatic parity_e decode_parity(input logic [1:0] mode);
        parity_e p;
        case (mode)
            2'b01:   p = PAR_EVEN;
            2'b10:   p = PAR_ODD;
            default: p = PAR_NONE;
        endcase
        return p;
    endfunction

    function automatic logic parity_bit(input logic acc, input parity_e mode);
        return (mode == PAR_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready write stream feeding the UART transmit FIFO.
interface uart_tx_fifo_if #(parameter int DW = 8);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; depth must be a power of two.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (count_r == CNT_W'(DEPTH));
    assign empty_o = (count_r == CNT_W'(0));
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign data_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end, runtime baud divisor, optional
// parity and one or two stop bits, LSB-first framing.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    uart_tx_fifo_if.slave                     s_if,
    input  logic [DIV_W-1:0]                  baud_div_i,
    input  logic [1:0]                        parity_mode_i,
    input  logic                              stop2_i,
    output logic                              tx_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int IDX_W = $clog2(DW);

    tx_state_e        state_r,  state_nxt_s;
    logic [DIV_W-1:0] cnt_r,    cnt_nxt_s;
    logic [IDX_W-1:0] idx_r,    idx_nxt_s;
    logic [DW-1:0]    shift_r,  shift_nxt_s;
    logic             acc_r,    acc_nxt_s;
    logic [DIV_W-1:0] div_r,    div_nxt_s;
    parity_e          par_r,    par_nxt_s;
    logic             stop2_r,  stop2_nxt_s;
    logic             tx_r,     tx_nxt_s;

    logic             push_s;
    logic             pop_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic [DW-1:0]    fifo_dout_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [DIV_W-1:0] eff_div_s;
    logic             bit_end_s;

    assign s_if.s_ready = (fifo_count_s < CNT_W'(FIFO_DEPTH));
    assign push_s       = s_if.s_valid && s_if.s_ready;
    assign fifo_count_o = fifo_count_s;
    assign busy_o       = (state_r != IDLE) || (fifo_count_s != CNT_W'(0));
    assign tx_o         = tx_r;
    assign eff_div_s    = (baud_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div_i;
    assign bit_end_s    = (cnt_r == (div_r - DIV_W'(1)));

    uart_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (s_if.s_data),
        .pop_i   (pop_s),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Frame sequencing; a pop (from IDLE or at the end of STOP) reloads the
    // whole frame context so config changes only take effect between frames.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + DIV_W'(1);
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        acc_nxt_s   = acc_r;
        div_nxt_s   = div_r;
        par_nxt_s   = par_r;
        stop2_nxt_s = stop2_r;
        pop_s       = 1'b0;
        tx_nxt_s    = 1'b1;

        case (state_r)
            IDLE: begin
                cnt_nxt_s = {DIV_W{1'b0}};
                pop_s     = !fifo_empty_s;
            end
            START: begin
                if (bit_end_s) begin
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    shift_nxt_s = shift_r >> 1;
                    acc_nxt_s   = acc_r ^ shift_r[0];
                    if (idx_r == IDX_W'(DW - 1)) begin
                        idx_nxt_s   = {IDX_W{1'b0}};
                        state_nxt_s = (par_r == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                // idx counts the first stop bit when two are requested
                if (bit_end_s) begin
                    cnt_nxt_s = {DIV_W{1'b0}};
                    if (stop2_r && (idx_r == {IDX_W{1'b0}})) begin
                        idx_nxt_s = IDX_W'(1);
                    end else begin
                        state_nxt_s = IDLE;
                        pop_s       = !fifo_empty_s;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {DIV_W{1'b0}};
            end
        endcase

        state_nxt_s = pop_s ? START                       : state_nxt_s;
        cnt_nxt_s   = pop_s ? {DIV_W{1'b0}}               : cnt_nxt_s;
        idx_nxt_s   = pop_s ? {IDX_W{1'b0}}               : idx_nxt_s;
        shift_nxt_s = pop_s ? fifo_dout_s                 : shift_nxt_s;
        acc_nxt_s   = pop_s ? 1'b0                        : acc_nxt_s;
        div_nxt_s   = pop_s ? eff_div_s                   : div_nxt_s;
        par_nxt_s   = pop_s ? decode_parity(parity_mode_i) : par_nxt_s;
        stop2_nxt_s = pop_s ? stop2_i                     : stop2_nxt_s;

        case (state_nxt_s)
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shift_nxt_s[0];
            PARITY:  tx_nxt_s = parity_bit(acc_nxt_s, par_nxt_s);
            STOP:    tx_nxt_s = 1'b1;
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // Frame state and the registered serial line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {DW{1'b0}};
            acc_r   <= 1'b0;
            div_r   <= DIV_W'(MIN_DIV);
            par_r   <= PAR_NONE;
            stop2_r <= 1'b0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            acc_r   <= acc_nxt_s;
            div_r   <= div_nxt_s;
            par_r   <= par_nxt_s;
            stop2_r <= stop2_nxt_s;
            tx_r    <= tx_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a line-timeline model.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd4;
    logic [1:0]       pmode = 2'b00;
    logic             stop2 = 1'b0;
    logic             tx;
    logic             busy;
    logic [2:0]       fcount;

    uart_tx_fifo_if #(.DW(DW)) sif ();

    uart_tx_fifo #(.DW(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_if          (sif),
        .baud_div_i    (baud_div),
        .parity_mode_i (pmode),
        .stop2_i       (stop2),
        .tx_o          (tx),
        .busy_o        (busy),
        .fifo_count_o  (fcount)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: words waiting, per-cycle line levels still to be driven, and the
    // edge index at which the line becomes free for the next frame.
    int             cyc    = 0;
    int             m_free = 0;
    logic [DW-1:0]  m_fifo[$];
    logic           m_line[$];
    logic           m_tx   = 1'b1;
    logic           e_busy = 1'b0;
    logic           e_rdy  = 1'b1;
    logic [2:0]     e_cnt  = 3'd0;

    task automatic model_step();
        logic          do_pop;
        logic          do_push;
        logic [DW-1:0] w;
        logic          bits[$];
        int            d;
        cyc++;
        do_pop  = (m_fifo.size() > 0) && (cyc >= m_free);
        do_push = sif.s_valid && (m_fifo.size() < DEPTH);
        if (do_pop) begin
            w = m_fifo.pop_front();
            d = (baud_div < 16'd2) ? 2 : int'(baud_div);
            bits.push_back(1'b0);
            for (int i = 0; i < DW; i++) bits.push_back(w[i]);
            if (pmode == 2'b01) bits.push_back(^w);
            if (pmode == 2'b10) bits.push_back(~^w);
            bits.push_back(1'b1);
            if (stop2) bits.push_back(1'b1);
            foreach (bits[b]) for (int r = 0; r < d; r++) m_line.push_back(bits[b]);
            m_free = cyc + d * bits.size();
        end
        if (do_push) m_fifo.push_back(sif.s_data);
        m_tx   = (m_line.size() > 0) ? m_line.pop_front() : 1'b1;
        e_cnt  = 3'(m_fifo.size());
        e_rdy  = (m_fifo.size() < DEPTH);
        e_busy = (cyc < m_free) || (m_fifo.size() != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_line.delete();
        m_free = cyc;
        m_tx   = 1'b1;
        e_busy = 1'b0;
        e_rdy  = 1'b1;
        e_cnt  = 3'd0;
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (tx !== 1'b1)        begin n_err++; $display("FAIL reset_tx got %b want 1", tx); end
        n_vec++; if (sif.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", sif.s_ready); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (fcount !== 3'd0)    begin n_err++; $display("FAIL reset_count got %0d want 0", fcount); end
        rst = 1'b0;
        model_reset();
    endtask

    // One frame from an idle line with fixed expectations for latency, length,
    // recovered data and (when exp_par >= 0) the parity bit.
    task automatic test_frame(input string name, input logic [7:0] data, input logic [15:0] div,
                              input logic [1:0] pm, input logic s2, input int exp_len, input int exp_par);
        logic       cap[$];
        logic [7:0] dec;
        int         d;
        int         blen;
        bit         counting;
        baud_div = div; pmode = pm; stop2 = s2;
        sif.s_valid = 1'b1; sif.s_data = data;
        tick();
        sif.s_valid = 1'b0;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL %s_early got tx=%b want 1", name, tx); end
        tick();
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL %s_start got tx=%b want 0", name, tx); end
        blen = 0; counting = 1'b1;
        for (int i = 0; i < exp_len + 4; i++) begin
            cap.push_back(tx);
            if (counting && busy) blen++; else counting = 1'b0;
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL %s cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         name, cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
            tick();
        end
        n_vec++; if (blen != exp_len) begin n_err++; $display("FAIL %s_len got %0d want %0d", name, blen, exp_len); end
        d = (div < 16'd2) ? 2 : int'(div);
        for (int i = 0; i < 8; i++) dec[i] = cap[(1 + i) * d + d / 2];
        n_vec++; if (dec !== data) begin n_err++; $display("FAIL %s_data got %h want %h", name, dec, data); end
        if (exp_par >= 0) begin
            n_vec++;
            if (cap[9 * d + d / 2] !== exp_par[0]) begin
                n_err++; $display("FAIL %s_parity got %b want %b", name, cap[9 * d + d / 2], exp_par[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[6];
        int         i;
        int         d;
        int         len;
        int         blen;
        int         max_cnt;
        d = $urandom_range(2, 5);
        baud_div = 16'(d); pmode = 2'($urandom); stop2 = 1'($urandom);
        len = d * (1 + DW + ((pmode == 2'b01 || pmode == 2'b10) ? 1 : 0) + (stop2 ? 2 : 1));
        foreach (words[k]) words[k] = 8'($urandom);
        i = 0; blen = 0; max_cnt = 0;
        for (int c = 0; c < 6 * len + 30; c++) begin
            sif.s_valid = (i < 6);
            sif.s_data  = words[(i < 6) ? i : 5];
            if (sif.s_valid && (m_fifo.size() < DEPTH)) i++;
            tick();
            if (tx === 1'b0 || blen > 0) blen += busy ? 1 : 0;
            if (int'(fcount) > max_cnt) max_cnt = int'(fcount);
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL b2b cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
        end
        sif.s_valid = 1'b0;
        n_vec++; if (max_cnt != DEPTH) begin n_err++; $display("FAIL b2b_full got max %0d want %0d", max_cnt, DEPTH); end
        n_vec++; if (blen != 6 * len)  begin n_err++; $display("FAIL b2b_len got %0d want %0d", blen, 6 * len); end
        n_vec++; if (fcount !== 3'd0)  begin n_err++; $display("FAIL b2b_drain got %0d want 0", fcount); end
    endtask

    task automatic test_baud_change();
        int blen;
        baud_div = 16'd4; pmode = 2'b00; stop2 = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = 8'h55;
        tick();
        sif.s_data = 8'h96;
        tick();
        sif.s_valid = 1'b0;
        // busy counted from the second accept edge: first pop edge onward
        blen = 1;
        for (int c = 0; c < 140; c++) begin
            if (c == 10) baud_div = 16'd8;
            blen += busy ? 1 : 0;
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL baud cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
            tick();
        end
        n_vec++; if (blen != 40 + 80 + 1) begin n_err++; $display("FAIL baud_len got %0d want 121", blen); end
    endtask

    task automatic test_reset_mid();
        baud_div = 16'd4; pmode = 2'b00; stop2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sif.s_valid = 1'b1; sif.s_data = 8'($urandom);
            tick();
        end
        sif.s_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick();
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL rstmid cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
        end
        n_vec++; if (fcount !== 3'd2) begin n_err++; $display("FAIL rstmid_queued got %0d want 2", fcount); end
        rst = 1'b1;
        #1;
        n_vec++; if (tx !== 1'b1)          begin n_err++; $display("FAIL rstmid_tx got %b want 1", tx); end
        n_vec++; if (fcount !== 3'd0)      begin n_err++; $display("FAIL rstmid_count got %0d want 0", fcount); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (sif.s_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", sif.s_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        test_frame("after_rst", 8'h3C, 16'd4, 2'b00, 1'b0, 40, -1);
    endtask

    task automatic test_simul();
        baud_div = 16'd2; pmode = 2'b00; stop2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sif.s_valid = 1'b1; sif.s_data = 8'($urandom);
            tick();
        end
        sif.s_valid = 1'b0;
        for (int c = 0; c < 40 && (cyc + 1 < m_free); c++) tick();
        sif.s_valid = 1'b1; sif.s_data = 8'($urandom);
        tick();
        sif.s_valid = 1'b0;
        n_vec++; if (fcount !== 3'd2) begin n_err++; $display("FAIL simul_count got %0d want 2", fcount); end
        for (int c = 0; c < 70; c++) begin
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL simul cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            sif.s_valid = ($urandom_range(0, 3) == 0);
            sif.s_data  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                baud_div = 16'($urandom_range(0, 5));
                pmode    = 2'($urandom);
                stop2    = 1'($urandom);
            end
            tick();
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL random cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
        end
        sif.s_valid = 1'b0;
        for (int c = 0; c < 600 && e_busy; c++) begin
            tick();
            n_vec++;
            if ({tx, busy, sif.s_ready, fcount} !== {m_tx, e_busy, e_rdy, e_cnt}) begin
                n_err++;
                $display("FAIL drain cyc=%0d got tx/busy/rdy/cnt %b%b%b/%0d want %b%b%b/%0d",
                         cyc, tx, busy, sif.s_ready, fcount, m_tx, e_busy, e_rdy, e_cnt);
            end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL random_idle got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_frame("basic",  8'hA5, 16'd4, 2'b00, 1'b0, 40, -1);
        test_frame("even",   8'h07, 16'd4, 2'b01, 1'b0, 44,  1);
        test_frame("odd",    8'h07, 16'd4, 2'b10, 1'b0, 44,  0);
        test_frame("stop2",  8'h07, 16'd4, 2'b00, 1'b1, 44, -1);
        test_frame("div0",   8'hC3, 16'd0, 2'b00, 1'b0, 20, -1);
        test_back_to_back();
        test_baud_change();
        test_reset_mid();
        test_simul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the serial peripheral subsystem. Accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first with a runtime baud divisor, optional even/odd parity and one or two stop bits. Replaces the fixed-format, unbuffered transmitter wherever firmware needs back-to-back frames or a runtime-selectable line format.

## Interface
- DW, 8: data bits per frame, legal 5..9
- FIFO_DEPTH, 4: FIFO entries, power of two, ≥2
- DIV_W, 16: width of the baud divisor
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- baud_div_i  in  DIV_W  clock cycles per bit; values 0 and 1 behave as 2
- parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 none
- stop2_i  in  1  0: one stop bit, 1: two stop bits
- s_valid_i  in  1  write request
- s_data_i  in  DW  word to send
- s_ready_o  out  1  FIFO can accept; equals (fifo_count_o < FIFO_DEPTH)
- tx_o  out  1  serial line, registered, idle high
- busy_o  out  1  frame in progress or FIFO non-empty
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

## Operation
- Push on a rising edge with s_valid_i && s_ready_o. Writes while full are dropped; s_ready_o is low, so no handshake occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop one word, latch the word, baud_div_i, parity_mode_i and stop2_i, then enter START. Otherwise stay in IDLE.
- Config inputs are sampled only at the pop. Changes mid-frame do not affect the current frame.
- Every bit lasts exactly the latched divisor D in clock cycles, counted by an internal bit-period counter. The counter is reset at each state entry.
- START: drives 0 for D cycles, then enters DATA.
- DATA: drives shift[0] for D cycles per bit, shifting right at each bit end. After DW bits, enters PARITY if parity is enabled, else STOP.
- PARITY: even mode drives the XOR of the data bits; odd mode drives its inverse. Lasts D cycles.
- STOP: drives 1 for D cycles, or 2·D cycles if stop2 is latched. At the end, if the FIFO is non-empty, pop and enter START directly with no idle cycle; otherwise enter IDLE.
- Frame length is D·(1 + DW + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- FIFO push and pop on the same edge leave the count unchanged. A pop never occurs on empty.
- busy_o = (state ≠ IDLE) || (fifo_count_o ≠ 0).

## Timing
- Reset values: tx_o=1, s_ready_o=1, busy_o=0, fifo_count_o=0, FSM in IDLE, FIFO flushed.
- Reset asserted mid-frame aborts the frame: tx_o goes high asynchronously and queued words are discarded.
- Latency from an idle line: word accepted at edge k; FIFO non-empty in cycle k+1; pop at edge k+1. tx_o falls at edge k+1 and stays low for D cycles.
- fifo_count_o updates on the edge following the push or pop.
- Back-to-back frames: the last stop-bit cycle is followed directly by the next start bit.
- tx_o is driven from next-state/bit logic through a flop, so it never glitches.

## Structure
- Package uart_pkg contains:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - tx_state_e enum
  - localparam MIN_DIV = 2
- Sub-module uart_fifo is a synchronous FIFO parameterised by width and depth. It provides push/pop, full/empty and count.
- Top-level logic: FSM, bit-period counter, bit index counter, shift register and parity accumulator.

## Test plan
- DW=8, D=4, parity none, one stop bit, push 0xA5:
  - tx_o falls one cycle after the accept.
  - Data bits are 1,0,1,0,0,1,0,1, each 4 cycles, followed by a 4-cycle stop bit. Total 40 cycles.
  - busy_o drops the cycle after the stop bit ends.
- Push 0x07 with even parity: parity bit = 1. With odd parity: parity bit = 0. With stop2_i=1, parity none: frame lasts 11·D cycles.
- FIFO_DEPTH=4, hold s_valid_i high with 6 words:
  - s_ready_o drops when the count reaches 4.
  - All 6 frames appear back-to-back with no idle gap.
  - fifo_count_o returns to 0.
- Change baud_div_i from 4 to 8 mid-frame: the current frame keeps 4-cycle bits and the next frame uses 8. baud_div_i=0 gives 2-cycle bits.
- Assert rst_i during the third data bit with 2 words queued:
  - tx_o goes high immediately; fifo_count_o=0, busy_o=0, s_ready_o=1.
  - A subsequent push of 0x3C transmits correctly.
- Push and pop on the same edge at count 2: fifo_count_o stays 2.
